// File: rtl/mux8_arbiter.sv
// 8-way round-robin arbiter driving a mux select; tenures are separated by one idle cycle.
// Define MUX8_ARB_TIMEOUT_EN to bound each tenure at HOLD_MAX cycles when others are waiting.
module mux8_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic       S0,
  output logic       S1,
  output logic       S2,
  output logic       valid,
  output logic       preempt
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("mux8_arbiter: HOLD_MAX must be in 2..255");
  end

  state_t      state_r;
  logic [2:0]  ptr_r;
  logic [2:0]  sel_r;
  logic [7:0]  gnt_r;
  logic        valid_r;
  logic [3:0]  pick_s;
  logic        pick_hit_s;
  logic [2:0]  pick_idx_s;

`ifdef MUX8_ARB_TIMEOUT_EN
  localparam logic [7:0] CNT_MAX = 8'(HOLD_MAX - 1);
  logic [7:0]  cnt_r;
  logic        preempt_r;
`endif

  // Returns {hit, index} of the first set request at or after p, wrapping 7 -> 0.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = p + 3'(i);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [7:0] onehot8(input logic [2:0] i);
    return 8'd1 << i;
  endfunction

  // Candidate owner for the next IDLE-state arbitration.
  always_comb begin
    pick_s = 4'd0;
    pick_s = rr_pick(req, ptr_r);
  end

  assign pick_hit_s = pick_s[3];
  assign pick_idx_s = pick_s[2:0];

  // Arbitration FSM; every output comes straight from a register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ptr_r     <= 3'd0;
      sel_r     <= 3'd0;
      gnt_r     <= 8'd0;
      valid_r   <= 1'b0;
`ifdef MUX8_ARB_TIMEOUT_EN
      cnt_r     <= 8'd0;
      preempt_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
`ifdef MUX8_ARB_TIMEOUT_EN
          preempt_r <= 1'b0;
`endif
          if (pick_hit_s) begin
            state_r <= GRANT;
            sel_r   <= pick_idx_s;
            gnt_r   <= onehot8(pick_idx_s);
            valid_r <= 1'b1;
`ifdef MUX8_ARB_TIMEOUT_EN
            cnt_r   <= 8'd0;
`endif
          end else begin
            gnt_r   <= 8'd0;
            valid_r <= 1'b0;
          end
        end
        GRANT: begin
          if (!req[sel_r]) begin
            state_r   <= IDLE;
            ptr_r     <= sel_r + 3'd1;
            gnt_r     <= 8'd0;
            valid_r   <= 1'b0;
`ifdef MUX8_ARB_TIMEOUT_EN
            preempt_r <= 1'b0;
          end else if (cnt_r == CNT_MAX && (req & ~gnt_r) != 8'd0) begin
            // Tenure exhausted with someone else waiting: force a handover.
            state_r   <= IDLE;
            ptr_r     <= sel_r + 3'd1;
            gnt_r     <= 8'd0;
            valid_r   <= 1'b0;
            preempt_r <= 1'b1;
          end else begin
            preempt_r <= 1'b0;
            if (cnt_r != CNT_MAX) begin
              cnt_r <= cnt_r + 8'd1;
            end else begin
              cnt_r <= cnt_r;
            end
`else
          end else begin
            gnt_r   <= gnt_r;
            valid_r <= 1'b1;
`endif
          end
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= 8'd0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt          = gnt_r;
  assign {S2, S1, S0} = sel_r;
  assign valid        = valid_r;
`ifdef MUX8_ARB_TIMEOUT_EN
  assign preempt      = preempt_r;
`else
  assign preempt      = 1'b0;
`endif

endmodule

// Output-consistency checker for mux8_arbiter; attach alongside the arbiter instance.
module mux8_arbiter_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [7:0] gnt,
  input logic       S0,
  input logic       S1,
  input logic       S2,
  input logic       valid
);

  logic seen_rst_r;

  // Arms the checks once a reset has been applied.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_rst_r <= 1'b1;
    end else begin
      seen_rst_r <= seen_rst_r;
    end
  end

  a_onehot0 : assert property (@(posedge clk) disable iff (!seen_rst_r) $onehot0(gnt));
  a_valid   : assert property (@(posedge clk) disable iff (!seen_rst_r) valid == (|gnt));
  a_select  : assert property (@(posedge clk) disable iff (!seen_rst_r)
                               valid |-> (gnt == (8'd1 << {S2, S1, S0})));

endmodule

// File: tb/tb_mux8_arbiter.sv
// Randomized + directed bench for mux8_arbiter with a queue-based scoreboard.
module tb_mux8_arbiter;

  localparam int HOLD = 4;
`ifdef MUX8_ARB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       preempt;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       s0, s1, s2;
  logic       valid;
  logic       preempt;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: owner -1 means nobody holds the mux.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  int m_sel   = 0;
  int m_pre   = 0;
  int m_age   = 0;

  mux8_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .S0(s0), .S1(s1), .S2(s2), .valid(valid), .preempt(preempt)
  );

  mux8_arbiter_chk chk_i (
    .clk(clk), .rst_n(rst_n), .gnt(gnt),
    .S0(s0), .S1(s1), .S2(s2), .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Applies the arbitration rules to the inputs seen at this edge.
  task automatic model_step();
    exp_t e;
    int   others;
    bit   found;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0; m_pre = 0; m_age = 0;
    end else if (m_owner < 0) begin
      m_pre = 0;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (!found && req[(m_ptr + k) % 8]) begin
          found   = 1'b1;
          m_owner = (m_ptr + k) % 8;
          m_sel   = m_owner;
          m_cnt   = 0;
          m_age   = 0;
        end
      end
    end else if (!req[m_owner]) begin
      m_ptr = (m_owner + 1) % 8; m_owner = -1; m_pre = 0;
    end else begin
      others = int'(req) & ~(1 << m_owner);
      if (TIMEOUT && m_cnt == HOLD - 1 && others != 0) begin
        m_ptr = (m_owner + 1) % 8; m_owner = -1; m_pre = 1;
      end else begin
        if (m_cnt < HOLD - 1) m_cnt++;
        m_age++;
        m_pre = 0;
      end
    end
    e.gnt     = (m_owner < 0) ? 8'd0 : 8'(1 << m_owner);
    e.sel     = 3'(m_sel);
    e.valid   = (m_owner >= 0);
    e.preempt = (m_pre != 0);
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, expv);
    end
  endtask

  // Monitor: every cycle the DUT has an expected response queued, compare it.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("gnt",     32'(gnt),          32'(e.gnt));
      chk("sel",     32'({s2, s1, s0}), 32'(e.sel));
      chk("valid",   32'(valid),        32'(e.valid));
      chk("preempt", 32'(preempt),      32'(e.preempt));
    end
  end

  task automatic cyc(input logic [7:0] r, input logic rn);
    @(negedge clk);
    req   = r;
    rst_n = rn;
    @(posedge clk);
    model_step();
  endtask

  initial begin
    logic [7:0] r;
    rst_n = 1'b0;
    req   = 8'd0;
    r     = 8'd0;
    cyc(8'h00, 1'b0);
    cyc(8'h00, 1'b0);

    // Single requester: grant, hold, release.
    for (int i = 0; i < 5; i++) cyc(8'h01, 1'b1);
    for (int i = 0; i < 3; i++) cyc(8'h00, 1'b1);

    // All requesting; each owner lets go after a short tenure -> full rotation.
    for (int i = 0; i < 40; i++) begin
      r = 8'hFF;
      if (m_owner >= 0 && m_age >= 2) r[m_owner[2:0]] = 1'b0;
      cyc(r, 1'b1);
    end

    // Owner 7 releases with requester 0 waiting -> wrap to 0.
    cyc(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cyc(8'h80, 1'b1);
    cyc(8'h01, 1'b1);
    for (int i = 0; i < 3; i++) cyc(8'h81, 1'b1);

    // Contention held for a long time: timeout handover or indefinite hold.
    cyc(8'h00, 1'b0);
    for (int i = 0; i < 14; i++) cyc(8'h06, 1'b1);

    // Reset mid-tenure of owner 5.
    cyc(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cyc(8'h20, 1'b1);
    for (int i = 0; i < 2; i++) cyc(8'h28, 1'b1);
    cyc(8'h28, 1'b0);
    for (int i = 0; i < 4; i++) cyc(8'h28, 1'b1);

    // Random traffic with sticky requests and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(3, 0) == 0) r = 8'($urandom()) & 8'($urandom());
      if (m_owner >= 0 && $urandom_range(7, 0) == 0) r[m_owner[2:0]] = 1'b0;
      cyc(r, ($urandom_range(255, 0) == 0) ? 1'b0 : 1'b1);
    end

    cyc(8'h00, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("drain", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
